// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode power-up sequencer: CMD0, CMD8, CMD55/ACMD41 polling, CMD58, with response checks.
// Define SD_INIT_V1_FALLBACK_EN to accept v1 cards that reject CMD8 with R1=0x05.

module sd_init_sequencer #(
    parameter int unsigned CMD0_RETRIES   = 8,
    parameter int unsigned ACMD41_RETRIES = 1000,
    parameter int unsigned WDOG_CYCLES    = 65535
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        start,
    output logic [47:0] spi_init_cmd_data,
    output logic        spi_init_cmd,
    input  logic        spi_init_busy,
    input  logic        spi_init_error,
    input  logic [47:0] spi_init_response,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  error_code,
    output logic        sdhc
);

    localparam logic [7:0]  CMD0_MAX   = 8'(CMD0_RETRIES);
    localparam logic [15:0] ACMD41_MAX = 16'(ACMD41_RETRIES);
    localparam logic [16:0] WDOG_MAX   = 17'(WDOG_CYCLES);

    localparam logic [2:0] ERR_CMD0   = 3'd1;
    localparam logic [2:0] ERR_CMD8   = 3'd2;
    localparam logic [2:0] ERR_ACMD41 = 3'd3;
    localparam logic [2:0] ERR_CMD58  = 3'd4;
    localparam logic [2:0] ERR_XFER   = 3'd5;
    localparam logic [2:0] ERR_WDOG   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_ACK, S_WAIT, S_CHECK, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [2:0] {
        C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
    } cmd_t;

    function automatic logic [47:0] frame_of(input cmd_t c, input logic v1);
        case (c)
            C_CMD0:   frame_of = 48'h40_00000000_95;
            C_CMD8:   frame_of = 48'h48_000001AA_87;
            C_CMD55:  frame_of = 48'h77_00000000_65;
            C_ACMD41: frame_of = v1 ? 48'h69_00000000_E5 : 48'h69_40000000_77;
            C_CMD58:  frame_of = 48'h7A_00000000_FD;
            default:  frame_of = 48'h40_00000000_95;
        endcase
    endfunction

    state_t      state_q;
    cmd_t        cmd_q;
    logic [47:0] cmd_data_q;
    logic        strobe_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [2:0]  code_q;
    logic        sdhc_q;
    logic [39:0] resp_q;
    logic        xfer_err_q;
    logic [7:0]  attempts_q;
    logic [15:0] pairs_q;
    logic [16:0] wdog_q;
    logic        v1_q;

    logic [7:0]  r1;
    logic [31:0] payload;
    logic        unused_bits;

    assign r1          = resp_q[39:32];
    assign payload     = resp_q[31:0];
    assign unused_bits = ^{spi_init_response[47:40], payload[29:12]};

    // Decision of the current cycle: what to issue next, or whether to finish/fail.
    logic        issue_d;
    logic        restart_d;
    logic        fail_d;
    logic        finish_d;
    cmd_t        issue_cmd_d;
    logic [2:0]  code_d;
    logic        sdhc_d;
    logic        v1_d;
    logic [7:0]  attempts_d;
    logic [15:0] pairs_d;
    logic [16:0] wdog_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        issue_d     = 1'b0;
        restart_d   = 1'b0;
        fail_d      = 1'b0;
        finish_d    = 1'b0;
        issue_cmd_d = C_CMD0;
        code_d      = 3'd0;
        sdhc_d      = 1'b0;
        v1_d        = v1_q;
        attempts_d  = attempts_q + 8'd1;
        pairs_d     = pairs_q + 16'd1;
        wdog_d      = wdog_q + 17'd1;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    issue_d   = 1'b1;
                    restart_d = 1'b1;
                end
            end
            S_ACK: begin
                if (wdog_d >= WDOG_MAX) begin
                    fail_d = 1'b1;
                    code_d = ERR_WDOG;
                end
            end
            S_WAIT: begin
                if (spi_init_busy && wdog_d >= WDOG_MAX) begin
                    fail_d = 1'b1;
                    code_d = ERR_WDOG;
                end
            end
            S_CHECK: begin
                if (xfer_err_q) begin
                    fail_d = 1'b1;
                    code_d = ERR_XFER;
                end else begin
                    case (cmd_q)
                        C_CMD0: begin
                            if (r1 == 8'h01) begin
                                issue_d     = 1'b1;
                                issue_cmd_d = C_CMD8;
                            end else if (attempts_d < CMD0_MAX) begin
                                issue_d     = 1'b1;
                                issue_cmd_d = C_CMD0;
                            end else begin
                                fail_d = 1'b1;
                                code_d = ERR_CMD0;
                            end
                        end
                        C_CMD8: begin
                            if (r1 == 8'h01 && payload[11:0] == 12'h1AA) begin
                                issue_d     = 1'b1;
                                issue_cmd_d = C_CMD55;
                            end
`ifdef SD_INIT_V1_FALLBACK_EN
                            else if (r1 == 8'h05) begin
                                issue_d     = 1'b1;
                                issue_cmd_d = C_CMD55;
                                v1_d        = 1'b1;
                            end
`endif
                            else begin
                                fail_d = 1'b1;
                                code_d = ERR_CMD8;
                            end
                        end
                        C_CMD55: begin
                            if (r1 == 8'h00 || r1 == 8'h01) begin
                                issue_d     = 1'b1;
                                issue_cmd_d = C_ACMD41;
                            end else begin
                                fail_d = 1'b1;
                                code_d = ERR_ACMD41;
                            end
                        end
                        C_ACMD41: begin
                            if (r1 == 8'h00) begin
`ifdef SD_INIT_V1_FALLBACK_EN
                                // v1 cards have no OCR CCS bit worth reading: byte addressing.
                                if (v1_q) begin
                                    finish_d = 1'b1;
                                    sdhc_d   = 1'b0;
                                end else
`endif
                                begin
                                    issue_d     = 1'b1;
                                    issue_cmd_d = C_CMD58;
                                end
                            end else if (r1 == 8'h01 && pairs_d < ACMD41_MAX) begin
                                issue_d     = 1'b1;
                                issue_cmd_d = C_CMD55;
                            end else begin
                                fail_d = 1'b1;
                                code_d = ERR_ACMD41;
                            end
                        end
                        C_CMD58: begin
                            if (r1 == 8'h00 && payload[31]) begin
                                finish_d = 1'b1;
                                sdhc_d   = payload[30];
                            end else begin
                                fail_d = 1'b1;
                                code_d = ERR_CMD58;
                            end
                        end
                        default: begin
                            fail_d = 1'b1;
                            code_d = ERR_CMD0;
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
        if (!res_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= C_CMD0;
            cmd_data_q <= '0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            code_q     <= 3'd0;
            sdhc_q     <= 1'b0;
            resp_q     <= '0;
            xfer_err_q <= 1'b0;
            attempts_q <= '0;
            pairs_q    <= '0;
            wdog_q     <= '0;
            v1_q       <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (fail_d) begin
                state_q <= S_FAIL;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                code_q  <= code_d;
            end else if (finish_d) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                sdhc_q  <= sdhc_d;
            end else if (issue_d) begin
                state_q    <= S_ISSUE;
                cmd_q      <= issue_cmd_d;
                cmd_data_q <= frame_of(issue_cmd_d, v1_d);
                strobe_q   <= 1'b1;
                busy_q     <= 1'b1;
            end else begin
                case (state_q)
                    S_ISSUE: begin
                        state_q <= S_ACK;
                        wdog_q  <= '0;
                    end
                    S_ACK: begin
                        state_q <= S_WAIT;
                        wdog_q  <= wdog_d;
                    end
                    S_WAIT: begin
                        if (!spi_init_busy) begin
                            state_q    <= S_CHECK;
                            resp_q     <= spi_init_response[39:0];
                            xfer_err_q <= spi_init_error;
                        end else begin
                            wdog_q <= wdog_d;
                        end
                    end
                    default: ;
                endcase
            end

            if (restart_d) begin
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                code_q     <= 3'd0;
                sdhc_q     <= 1'b0;
                attempts_q <= '0;
                pairs_q    <= '0;
                v1_q       <= 1'b0;
            end

            if (state_q == S_CHECK) begin
                v1_q <= v1_d;
                if (cmd_q == C_CMD0)   attempts_q <= attempts_d;
                if (cmd_q == C_ACMD41) pairs_q    <= pairs_d;
            end
        end
    end

    assign spi_init_cmd_data = cmd_data_q;
    assign spi_init_cmd      = strobe_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;
    assign error_code        = code_q;
    assign sdhc              = sdhc_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Scoreboard bench for sd_init_sequencer: a scripted card answers each command, a protocol-level
// model predicts the frame sequence and final outcome, a monitor compares as the DUT produces them.

module tb_sd_init_sequencer;

    localparam int CMD0_R = 8;
    localparam int A41_R  = 4;
    localparam int WDOG   = 100;

    localparam logic [47:0] F_CMD0   = 48'h40_00000000_95;
    localparam logic [47:0] F_CMD8   = 48'h48_000001AA_87;
    localparam logic [47:0] F_CMD55  = 48'h77_00000000_65;
    localparam logic [47:0] F_A41_HC = 48'h69_40000000_77;
    localparam logic [47:0] F_A41_V1 = 48'h69_00000000_E5;
    localparam logic [47:0] F_CMD58  = 48'h7A_00000000_FD;

`ifdef SD_INIT_V1_FALLBACK_EN
    localparam bit FALLBACK = 1'b1;
`else
    localparam bit FALLBACK = 1'b0;
`endif

    typedef struct packed {
        logic       done;
        logic       error;
        logic [2:0] code;
        logic       sdhc;
    } out_t;

    logic        clk;
    logic        res_n;
    logic        start;
    logic [47:0] spi_init_cmd_data;
    logic        spi_init_cmd;
    logic        spi_init_busy;
    logic        spi_init_error;
    logic [47:0] spi_init_response;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  error_code;
    logic        sdhc;

    sd_init_sequencer #(
        .CMD0_RETRIES  (CMD0_R),
        .ACMD41_RETRIES(A41_R),
        .WDOG_CYCLES   (WDOG)
    ) dut (
        .clk              (clk),
        .res_n            (res_n),
        .start            (start),
        .spi_init_cmd_data(spi_init_cmd_data),
        .spi_init_cmd     (spi_init_cmd),
        .spi_init_busy    (spi_init_busy),
        .spi_init_error   (spi_init_error),
        .spi_init_response(spi_init_response),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .error_code       (error_code),
        .sdhc             (sdhc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] exp_frames[$];
    out_t        exp_out[$];

    // Card script for the current scenario.
    int          sc_cmd0_bad;
    logic [7:0]  sc_cmd8_r1;
    logic [31:0] sc_cmd8_pay;
    logic [7:0]  sc_cmd55_r1;
    int          sc_a41_busy;
    logic [7:0]  sc_cmd58_r1;
    logic [31:0] sc_cmd58_pay;
    int          sc_err_at;
    int          sc_hang_at;

    int n_strobe  = 0;
    int cmd0_seen = 0;
    int a41_seen  = 0;
    bit resp_idle = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // ---------------- reference model ----------------
    int   m_n;
    out_t m_out;

    function automatic out_t mk_out(input bit d, input bit e, input logic [2:0] c, input bit s);
        out_t o;
        o.done  = d;
        o.error = e;
        o.code  = c;
        o.sdhc  = s;
        return o;
    endfunction

    // Records one issued command; returns 1 when this command ends the run abnormally.
    function automatic bit emit(input logic [47:0] f);
        exp_frames.push_back(f);
        m_n++;
        if (m_n == sc_err_at) begin
            m_out = mk_out(0, 1, 3'd5, 0);
            return 1'b1;
        end
        if (m_n == sc_hang_at) begin
            m_out = mk_out(0, 1, 3'd6, 0);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void run_model();
        bit ok;
        bit v1;
        m_n = 0;
        ok  = 1'b0;
        for (int i = 1; i <= CMD0_R && !ok; i++) begin
            if (emit(F_CMD0)) return;
            if (i > sc_cmd0_bad) ok = 1'b1;
        end
        if (!ok) begin
            m_out = mk_out(0, 1, 3'd1, 0);
            return;
        end
        if (emit(F_CMD8)) return;
        if (sc_cmd8_r1 == 8'h01 && sc_cmd8_pay[11:0] == 12'h1AA) v1 = 1'b0;
        else if (FALLBACK && sc_cmd8_r1 == 8'h05) v1 = 1'b1;
        else begin
            m_out = mk_out(0, 1, 3'd2, 0);
            return;
        end
        ok = 1'b0;
        for (int p = 1; p <= A41_R && !ok; p++) begin
            if (emit(F_CMD55)) return;
            if (sc_cmd55_r1 > 8'h01) begin
                m_out = mk_out(0, 1, 3'd3, 0);
                return;
            end
            if (emit(v1 ? F_A41_V1 : F_A41_HC)) return;
            if (p > sc_a41_busy) ok = 1'b1;
        end
        if (!ok) begin
            m_out = mk_out(0, 1, 3'd3, 0);
            return;
        end
        if (v1) begin
            m_out = mk_out(1, 0, 3'd0, 0);
            return;
        end
        if (emit(F_CMD58)) return;
        if (sc_cmd58_r1 == 8'h00 && sc_cmd58_pay[31]) m_out = mk_out(1, 0, 3'd0, sc_cmd58_pay[30]);
        else m_out = mk_out(0, 1, 3'd4, 0);
    endfunction

    // ---------------- card responder ----------------
    initial begin
        logic [47:0] f;
        logic [7:0]  r1;
        logic [31:0] pay;
        bit          terr;
        bit          hang;
        int          t_strobe;
        int          waited;
        spi_init_busy     = 1'b0;
        spi_init_error    = 1'b0;
        spi_init_response = '0;
        forever begin
            @(negedge clk);
            if (res_n && spi_init_cmd) begin
                resp_idle = 1'b0;
                n_strobe++;
                t_strobe = cyc;
                f   = spi_init_cmd_data;
                pay = $urandom;
                case (f[45:40])
                    6'd0: begin
                        cmd0_seen++;
                        r1 = (cmd0_seen <= sc_cmd0_bad) ? 8'hFF : 8'h01;
                    end
                    6'd8: begin
                        r1  = sc_cmd8_r1;
                        pay = sc_cmd8_pay;
                    end
                    6'd55: r1 = sc_cmd55_r1;
                    6'd41: begin
                        a41_seen++;
                        r1 = (a41_seen <= sc_a41_busy) ? 8'h01 : 8'h00;
                    end
                    6'd58: begin
                        r1  = sc_cmd58_r1;
                        pay = sc_cmd58_pay;
                    end
                    default: r1 = 8'hFF;
                endcase
                terr = (n_strobe == sc_err_at);
                hang = (n_strobe == sc_hang_at);
                @(posedge clk);
                #1 spi_init_busy = 1'b1;
                if (hang) begin
                    waited = 0;
                    while (!error && waited < 300) begin
                        @(negedge clk);
                        waited++;
                    end
                    check("wdog_latency", 64'(cyc - t_strobe), 64'(WDOG + 1));
                    spi_init_busy = 1'b0;
                end else begin
                    repeat ($urandom_range(1, 4)) @(posedge clk);
                    #1;
                    if (busy) check("cmd_data_hold", spi_init_cmd_data, f);
                    spi_init_response = {8'($urandom), r1, pay};
                    spi_init_error    = terr;
                    spi_init_busy     = 1'b0;
                    @(posedge clk);
                    #1 spi_init_error = 1'b0;
                end
                resp_idle = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit prev_cmd;
        bit prev_busy;
        prev_cmd  = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (res_n) begin
                if (spi_init_cmd) begin
                    check("strobe_width", 64'(prev_cmd), 64'd0);
                    if (!prev_cmd) begin
                        if (exp_frames.size() == 0)
                            fail_now("unexpected_strobe", $sformatf("frame %h with none expected", spi_init_cmd_data));
                        else
                            check("frame", spi_init_cmd_data, exp_frames.pop_front());
                    end
                end
                if (prev_busy && !busy && (done || error)) begin
                    if (exp_out.size() == 0)
                        fail_now("unexpected_outcome", $sformatf("done=%0b error=%0b code=%0d", done, error, error_code));
                    else
                        check("outcome", 64'({done, error, error_code, sdhc}), 64'(exp_out.pop_front()));
                end
            end
            prev_cmd  = spi_init_cmd;
            prev_busy = busy;
        end
    end

    // ---------------- driver ----------------
    task automatic set_nominal();
        sc_cmd0_bad  = 0;
        sc_cmd8_r1   = 8'h01;
        sc_cmd8_pay  = 32'h0000_01AA;
        sc_cmd55_r1  = 8'h01;
        sc_a41_busy  = 2;
        sc_cmd58_r1  = 8'h00;
        sc_cmd58_pay = 32'hC0FF_8000;
        sc_err_at    = 0;
        sc_hang_at   = 0;
    endtask

    task automatic wait_resp_idle();
        int w = 0;
        while (!resp_idle && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!resp_idle) fail_now("responder_stuck", "card model never released");
    endtask

    task automatic launch();
        wait_resp_idle();
        n_strobe  = 0;
        cmd0_seen = 0;
        a41_seen  = 0;
        run_model();
        exp_out.push_back(m_out);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_state", 64'({busy, done, error, error_code, sdhc}), 64'(7'b100_0000));
    endtask

    task automatic run_scenario(input bit poke_start);
        int w;
        launch();
        if (poke_start) begin
            repeat ($urandom_range(2, 20)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        end
        w = 0;
        while ((exp_frames.size() != 0 || exp_out.size() != 0) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        if (exp_frames.size() != 0 || exp_out.size() != 0)
            fail_now("scenario_timeout", $sformatf("%0d frames, %0d outcomes pending", exp_frames.size(), exp_out.size()));
        exp_frames.delete();
        exp_out.delete();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        res_n = 1'b0;
        start = 1'b0;
        set_nominal();
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({spi_init_cmd_data, spi_init_cmd, busy, done, error, error_code, sdhc}), 64'd0);
        res_n = 1'b1;
        @(negedge clk);

        set_nominal();                                    run_scenario(0);  // happy path, SDHC
        set_nominal(); sc_cmd0_bad = 3;                   run_scenario(0);
        set_nominal(); sc_cmd0_bad = 8;                   run_scenario(0);
        set_nominal(); sc_cmd8_pay = 32'h0000_01AB;       run_scenario(0);
        set_nominal(); sc_a41_busy = 100;                 run_scenario(0);
        set_nominal(); sc_a41_busy = 3;                   run_scenario(0);
        set_nominal(); sc_err_at = 9;                     run_scenario(0);
        set_nominal(); sc_err_at = 1;                     run_scenario(0);
        set_nominal(); sc_hang_at = 3;                    run_scenario(0);
        set_nominal(); sc_cmd55_r1 = 8'h05;               run_scenario(0);
        set_nominal(); sc_cmd58_pay = 32'h00FF_8000;      run_scenario(0);
        set_nominal(); sc_cmd58_pay = 32'h80FF_8000;      run_scenario(0);
        set_nominal(); sc_cmd58_r1 = 8'h01;               run_scenario(0);
        set_nominal(); sc_cmd8_r1 = 8'h05;                run_scenario(0);
        set_nominal(); sc_cmd8_r1 = 8'h05; sc_a41_busy = 1; run_scenario(1);

        // Reset in the middle of the first ACMD41, then a clean rerun from CMD0.
        set_nominal();
        launch();
        w = 0;
        while (n_strobe < 4 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (n_strobe < 4) fail_now("reach_acmd41", "fourth command never issued");
        repeat (2) @(negedge clk);
        res_n = 1'b0;
        @(negedge clk);
        check("reset_mid_cmd",
              64'({spi_init_cmd_data, spi_init_cmd, busy, done, error, error_code, sdhc}), 64'd0);
        exp_frames.delete();
        exp_out.delete();
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        repeat (12) @(negedge clk);
        check("idle_after_reset", 64'({busy, spi_init_cmd}), 64'd0);
        set_nominal(); run_scenario(0);

        for (int k = 0; k < 25; k++) begin
            set_nominal();
            sc_cmd0_bad = $urandom_range(0, 9);
            case ($urandom_range(0, 9))
                0: sc_cmd8_pay = 32'h0000_01AB;
                1: sc_cmd8_r1  = 8'h05;
                2: sc_cmd8_r1  = 8'h00;
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) sc_cmd55_r1 = 8'h05;
            else sc_cmd55_r1 = 8'($urandom_range(0, 1));
            sc_a41_busy = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) sc_cmd58_r1 = 8'h01;
            sc_cmd58_pay = $urandom;
            if ($urandom_range(0, 4) != 0) sc_cmd58_pay[31] = 1'b1;
            if ($urandom_range(0, 9) == 0) sc_err_at = $urandom_range(1, 12);
            run_scenario(bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
